// File: rtl/motion_dir_ctrl.sv
// motion_dir_ctrl: switch-to-direction controller.
// Raw direction switches are synchronised, debounced as a whole vector,
// validated (at most one active) and turned into a registered one-hot
// motion direction. Any change between two different non-zero directions
// is separated by an all-off dead interval of DEAD_CYCLES clocks.
module motion_dir_ctrl #(
  parameter int NUM_DIRS        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DEAD_CYCLES     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_DIRS-1:0] sw,
  output logic [NUM_DIRS-1:0] motiondir,
  output logic                busy,
  output logic                fault
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DCNT_W = $clog2(DEAD_CYCLES + 1);
  localparam int ONES_W = $clog2(NUM_DIRS + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEAD_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  // Synchroniser and debounce state
  logic [NUM_DIRS-1:0] s1;
  logic [NUM_DIRS-1:0] s2;
  logic [NUM_DIRS-1:0] cand;
  logic [NUM_DIRS-1:0] cand_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [NUM_DIRS-1:0] stable;

  // Request decode
  logic [ONES_W-1:0]   ones;
  logic                req_dir;
  logic                req_multi;

  // Direction FSM state
  state_t              state;
  state_t              state_nxt;
  logic [NUM_DIRS-1:0] cur;
  logic [NUM_DIRS-1:0] cur_nxt;
  logic [NUM_DIRS-1:0] pend;
  logic [NUM_DIRS-1:0] pend_nxt;
  logic [DCNT_W-1:0]   dcnt;
  logic [DCNT_W-1:0]   dcnt_nxt;

  // Registered output next values
  logic [NUM_DIRS-1:0] motiondir_nxt;
  logic                busy_nxt;
  logic                fault_nxt;

  // Two-flop synchroniser, no logic between the stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

  // Debounce counter next value: restart on any change, saturate at the limit
  always_comb begin
    cand_nxt = cand;
    cnt_nxt  = cnt;
    if (s2 != cand) begin
      cand_nxt = s2;
      cnt_nxt  = CNT_W'(1);
    end else if (cnt < CNT_MAX) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Debounce registers; the vector is accepted on the edge the count reaches
  // the limit, so the FSM sees it one edge later (DEBOUNCE_CYCLES+3 total)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      cand <= cand_nxt;
      cnt  <= cnt_nxt;
      if (cnt_nxt == CNT_MAX) begin
        stable <= cand_nxt;
      end
    end
  end

  // Classify the debounced vector: stop, single direction or invalid
  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < NUM_DIRS; i++) begin
      ones = ones + ONES_W'(stable[i]);
    end
    req_dir   = (ones == ONES_W'(1));
    req_multi = (ones > ONES_W'(1));
  end

  // Direction FSM state register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      pend      <= '0;
      dcnt      <= '0;
      motiondir <= '0;
      busy      <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur       <= cur_nxt;
      pend      <= pend_nxt;
      dcnt      <= dcnt_nxt;
      motiondir <= motiondir_nxt;
      busy      <= busy_nxt;
      fault     <= fault_nxt;
    end
  end

  // Next-state logic; outputs derive from the next state so they are
  // registered yet aligned with the state they describe
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    pend_nxt  = pend;
    dcnt_nxt  = dcnt;
    case (state)
      IDLE: begin
        if (req_dir) begin
          state_nxt = RUN;
          cur_nxt   = stable;
        end
      end
      RUN: begin
        if (!req_dir) begin
          state_nxt = IDLE;
        end else if (stable != cur) begin
          state_nxt = DEAD;
          pend_nxt  = stable;
          dcnt_nxt  = DCNT_W'(1);
        end
      end
      DEAD: begin
        if (!req_dir) begin
          state_nxt = IDLE;
        end else if (stable == pend) begin
          if (dcnt == DCNT_MAX) begin
            state_nxt = RUN;
            cur_nxt   = pend;
          end else begin
            dcnt_nxt = dcnt + DCNT_W'(1);
          end
        end else begin
          pend_nxt = stable;
          dcnt_nxt = DCNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    motiondir_nxt = (state_nxt == RUN) ? cur_nxt : '0;
    busy_nxt      = (state_nxt == DEAD);
    fault_nxt     = req_multi;
  end

endmodule
